keypad_debouncer: RTL and testbench

Parametrised multi-channel key debouncer for the front-panel and keypad inputs. It replaces the fixed 4-key debouncer. Each of N_KEYS raw inputs passes through:
- a synchroniser,
- a per-channel debounce state machine,
- an optional auto-repeat timer.

It produces a clean level plus single-cycle press, release and repeat strobes for the vending controller FSM.

---
 rtl/keypad_debouncer_pkg.sv | 23 ++
 rtl/keypad_debouncer_channel.sv | 152 +++++++++++++++
 rtl/keypad_debouncer.sv | 60 ++++++
 tb/tb_keypad_debouncer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_debouncer_pkg.sv
// rtl/keypad_debouncer_pkg.sv - shared FSM encodings and counter width helpers
package keypad_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } kd_state_t;

  // Bits needed to hold 0..max_val; never less than 1 so degenerate
  // parameter values still give a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_debouncer_channel.sv
// rtl/keypad_debouncer_channel.sv - synchroniser, debounce FSM and repeat timer for one key
// Ports: clk, reset (async, active-low), key_in (raw pin), press_set (press accepted
// this cycle, unregistered), key_level/key_press/key_release/key_repeat (registered).
module debounce_channel
  import keypad_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW_IN   = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic press_set,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic                   key_raw;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  kd_state_t              state;
  logic [CW-1:0]          cnt;
  logic                   rel_done;

  // Normalise polarity before the first flop so the reset value 0 always
  // means "released" regardless of ACTIVE_LOW_IN.
  assign key_raw = key_in ^ (ACTIVE_LOW_IN != 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Acceptance is decided one count early so the strobe lands on the edge
  // where the stable-sample count reaches DEBOUNCE_CYCLES.
  assign press_set = (state == PRESS_WAIT) && s && (cnt == CNT_LAST);
  assign rel_done  = (state == RELEASE_WAIT) && !s && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (press_set) begin
            state     <= PRESSED;
            cnt       <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (rel_done) begin
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

      logic [RW-1:0] rpt;
      logic [RW-1:0] rpt_last;
      logic          rpt_periodic;
      logic          rep_q;

      // First interval is REPEAT_DELAY, every later one REPEAT_PERIOD.
      assign rpt_last = rpt_periodic ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);

      // Only counts while PRESSED with the key still seen down; RELEASE_WAIT
      // leaves rpt untouched so a release bounce keeps the cadence.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rpt          <= '0;
          rpt_periodic <= 1'b0;
          rep_q        <= 1'b0;
        end else begin
          rep_q <= 1'b0;
          if (press_set || rel_done) begin
            rpt          <= '0;
            rpt_periodic <= 1'b0;
          end else if ((state == PRESSED) && s) begin
            if (rpt == rpt_last) begin
              rpt          <= '0;
              rpt_periodic <= 1'b1;
              rep_q        <= 1'b1;
            end else begin
              rpt <= rpt + 1'b1;
            end
          end
        end
      end

      assign key_repeat = rep_q;
    end else begin : g_no_repeat
      assign key_repeat = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/keypad_debouncer.sv
// rtl/keypad_debouncer.sv - N_KEYS-channel key debouncer with press/release/repeat strobes
// Ports: clk, reset (async, active-low), key_in[N_KEYS] raw pins; key_level,
// key_press, key_release, key_repeat per channel; any_press = OR of key_press.
module keypad_debouncer
  import keypad_debouncer_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW_IN   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              any_press
);

  logic [N_KEYS-1:0] press_set;

  genvar g;
  generate
    for (g = 0; g < N_KEYS; g++) begin : g_ch
      debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (REPEAT_EN),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .ACTIVE_LOW_IN  (ACTIVE_LOW_IN)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in[g]),
        .press_set  (press_set[g]),
        .key_level  (key_level[g]),
        .key_press  (key_press[g]),
        .key_release(key_release[g]),
        .key_repeat (key_repeat[g])
      );
    end
  endgenerate

  // Registered from the same condition that sets each key_press flop, so it
  // is high in exactly the cycles any key_press is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_set;
    end
  end

endmodule

// File: tb/tb_keypad_debouncer.sv
// tb/tb_keypad_debouncer.sv - scoreboard bench for keypad_debouncer
module tb_keypad_debouncer;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_REPEAT  = 2;
  localparam int LAT       = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_in = 4'h0;
  logic [3:0] key_in_al = 4'hF;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic       any_press;
  logic [3:0] al_level, al_press, al_release, al_repeat;
  logic       al_any;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int cyc;
    int dut;
    int key;
    int kind;
  } ev_t;
  ev_t sb[$];

  keypad_debouncer #(
    .N_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .ACTIVE_LOW_IN(0)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat),
    .any_press(any_press)
  );

  keypad_debouncer #(
    .N_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .ACTIVE_LOW_IN(1)
  ) dut_al (
    .clk(clk), .reset(reset), .key_in(key_in_al), .key_level(al_level),
    .key_press(al_press), .key_release(al_release), .key_repeat(al_repeat),
    .any_press(al_any)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: pop events due now and compare against all strobes of both DUTs.
  always @(negedge clk) begin
    logic [1:0][3:0] ep, er, et, op, orl, ot;
    logic [1:0]      oa;
    if (mon_en) begin
      ep = '0; er = '0; et = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            K_PRESS:   ep[sb[i].dut][sb[i].key] = 1'b1;
            K_RELEASE: er[sb[i].dut][sb[i].key] = 1'b1;
            default:   et[sb[i].dut][sb[i].key] = 1'b1;
          endcase
          sb.delete(i);
        end
      end
      op[0] = key_press;  orl[0] = key_release; ot[0] = key_repeat; oa[0] = any_press;
      op[1] = al_press;   orl[1] = al_release;  ot[1] = al_repeat;  oa[1] = al_any;
      for (int d = 0; d < 2; d++) begin
        if ((ep[d] | er[d] | et[d]) != 4'h0 || (op[d] | orl[d] | ot[d]) !== 4'h0 || oa[d] !== 1'b0) begin
          n_checks++;
          if (op[d] !== ep[d] || orl[d] !== er[d] || ot[d] !== et[d] || oa[d] !== (|ep[d])) begin
            n_errors++;
            $display("FAIL strobes dut%0d cyc %0d: got press=%b release=%b repeat=%b any=%b, want press=%b release=%b repeat=%b any=%b",
                     d, cyc, op[d], orl[d], ot[d], oa[d], ep[d], er[d], et[d], |ep[d]);
          end
        end
      end
    end
  end

  task automatic push(input int t, input int d, input int k, input int kind);
    ev_t e;
    e.cyc = t; e.dut = d; e.key = k; e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({key_level, key_press, key_release, key_repeat, any_press} !== 17'h0) begin
      n_errors++;
      $display("FAIL reset_main: got %h, want 0", {key_level, key_press, key_release, key_repeat, any_press});
    end
    repeat (8) @(negedge clk);
    n_checks++;
    if ({al_level, al_press, al_release, al_repeat, al_any} !== 17'h0) begin
      n_errors++;
      $display("FAIL reset_active_low_idle: got %h, want 0", {al_level, al_press, al_release, al_repeat, al_any});
    end
  endtask

  task automatic test_clean_press;
    int c;
    @(negedge clk);
    key_in[0] = 1'b1;
    c = cyc;
    push(c + LAT, 0, 0, K_PRESS);
    push(c + 16, 0, 0, K_REPEAT);
    push(c + 21, 0, 0, K_REPEAT);
    wait_until(c + LAT - 1);
    n_checks++;
    if (key_level[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL press_level_early: got %b, want 0", key_level[0]);
    end
    wait_until(c + LAT);
    n_checks++;
    if (key_level[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL press_level: got %b, want 1", key_level[0]);
    end
    wait_until(c + 20);
    key_in[0] = 1'b0;
    push(c + 20 + LAT, 0, 0, K_RELEASE);
    wait_until(c + 20 + LAT - 1);
    n_checks++;
    if (key_level[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL release_level_early: got %b, want 1", key_level[0]);
    end
    wait_until(c + 20 + LAT);
    n_checks++;
    if (key_level[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL release_level: got %b, want 0", key_level[0]);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch;
    int c;
    @(negedge clk);
    key_in[1] = 1'b1;
    c = cyc;
    wait_until(c + 3);
    key_in[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (key_level[1] !== 1'b0) begin
        n_errors++;
        $display("FAIL glitch_level cyc %0d: got %b, want 0", cyc, key_level[1]);
      end
    end
  endtask

  task automatic test_release_bounce;
    int c;
    @(negedge clk);
    key_in[2] = 1'b1;
    c = cyc;
    push(c + LAT, 0, 2, K_PRESS);
    wait_until(c + 8);
    key_in[2] = 1'b0;
    wait_until(c + 10);
    key_in[2] = 1'b1;
    wait_until(c + 11);
    key_in[2] = 1'b0;
    push(c + 11 + LAT, 0, 2, K_RELEASE);
    while (cyc < c + 11 + LAT) begin
      n_checks++;
      if (key_level[2] !== 1'b1) begin
        n_errors++;
        $display("FAIL bounce_level cyc %0d: got %b, want 1", cyc, key_level[2]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (key_level[2] !== 1'b0) begin
      n_errors++;
      $display("FAIL bounce_release_level: got %b, want 0", key_level[2]);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_auto_repeat;
    int c;
    int p;
    @(negedge clk);
    key_in[3] = 1'b1;
    c = cyc;
    p = c + LAT;
    push(p, 0, 3, K_PRESS);
    for (int k = 10; k <= 25; k += 5) push(p + k, 0, 3, K_REPEAT);
    wait_until(p + 26);
    key_in[3] = 1'b0;
    push(p + 26 + LAT, 0, 3, K_RELEASE);
    wait_until(p + 26 + LAT + 20);
    n_checks++;
    if (key_level[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL repeat_final_level: got %b, want 0", key_level[3]);
    end
  endtask

  task automatic test_simultaneous;
    int c;
    @(negedge clk);
    key_in[0] = 1'b1;
    key_in[3] = 1'b1;
    c = cyc;
    push(c + LAT, 0, 0, K_PRESS);
    push(c + LAT, 0, 3, K_PRESS);
    wait_until(c + LAT);
    n_checks++;
    if (key_level !== 4'b1001) begin
      n_errors++;
      $display("FAIL simul_level: got %b, want 1001", key_level);
    end
    wait_until(c + 9);
    key_in = 4'h0;
    push(c + 9 + LAT, 0, 0, K_RELEASE);
    push(c + 9 + LAT, 0, 3, K_RELEASE);
    wait_until(c + 25);
  endtask

  task automatic test_async_reset;
    int c;
    @(negedge clk);
    key_in[0] = 1'b1;
    c = cyc;
    push(c + LAT, 0, 0, K_PRESS);
    wait_until(c + 8);
    key_in[1] = 1'b1;
    wait_until(c + 12);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({key_level, key_press, key_release, key_repeat, any_press} !== 17'h0) begin
      n_errors++;
      $display("FAIL async_reset: got %h, want 0", {key_level, key_press, key_release, key_repeat, any_press});
    end
    key_in = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (key_level !== 4'h0) begin
      n_errors++;
      $display("FAIL post_reset_level: got %b, want 0000", key_level);
    end
  endtask

  task automatic test_active_low;
    int c;
    @(negedge clk);
    key_in_al[0] = 1'b0;
    c = cyc;
    push(c + LAT, 1, 0, K_PRESS);
    wait_until(c + LAT - 1);
    n_checks++;
    if (al_level[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL al_level_early: got %b, want 0", al_level[0]);
    end
    wait_until(c + LAT);
    n_checks++;
    if (al_level !== 4'b0001) begin
      n_errors++;
      $display("FAIL al_level: got %b, want 0001", al_level);
    end
    wait_until(c + 10);
    key_in_al[0] = 1'b1;
    push(c + 10 + LAT, 1, 0, K_RELEASE);
    wait_until(c + 25);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_async_reset();
    test_active_low();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
